// File: rtl/riscv_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_control_unit
// Purpose  : RV32I-subset main/ALU decoder with registered control outputs.
//            Optional abs instruction (custom-0) enabled by CONTROLLER_ABS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       bge,
  input  logic       lt,
  output logic [1:0] PCSrc,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic [2:0] ALUControl,
  output logic       ALUSrc1,
  output logic [1:0] ALUSrc2,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       Abs_src
);

  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_JALR = 7'd103;
  localparam logic [6:0] OP_LUI  = 7'd55;
  localparam logic [6:0] OP_ABS  = 7'd11;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  logic [1:0] pc_src_d;
  logic [1:0] result_src_d;
  logic       mem_write_d;
  logic [2:0] alu_ctrl_d;
  logic       alu_src1_d;
  logic [1:0] alu_src2_d;
  logic [2:0] imm_src_d;
  logic       reg_write_d;
  logic       abs_src_d;
  logic       illegal;
  logic       taken;

  always_comb begin
    pc_src_d     = 2'b00;
    result_src_d = 2'b00;
    mem_write_d  = 1'b0;
    alu_ctrl_d   = ALU_ADD;
    alu_src1_d   = 1'b0;
    alu_src2_d   = 2'b00;
    imm_src_d    = 3'b000;
    reg_write_d  = 1'b0;
    abs_src_d    = 1'b0;
    illegal      = 1'b0;
    taken        = 1'b0;

    unique case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        case (func3)
          3'd0: begin
            if (func7 == 7'd0)       alu_ctrl_d = ALU_ADD;
            else if (func7 == 7'd32) alu_ctrl_d = ALU_SUB;
            else                     illegal    = 1'b1;
          end
          3'd7:    alu_ctrl_d = ALU_AND;
          3'd6:    alu_ctrl_d = ALU_OR;
          3'd4:    alu_ctrl_d = ALU_XOR;
          3'd2:    alu_ctrl_d = ALU_SLT;
          3'd3:    alu_ctrl_d = ALU_SLTU;
          default: illegal    = 1'b1;
        endcase
      end
      OP_I: begin
        reg_write_d = 1'b1;
        alu_src2_d  = 2'b01;
        case (func3)
          3'd0:    alu_ctrl_d = ALU_ADD;
          3'd4:    alu_ctrl_d = ALU_XOR;
          3'd6:    alu_ctrl_d = ALU_OR;
          3'd2:    alu_ctrl_d = ALU_SLT;
          3'd3:    alu_ctrl_d = ALU_SLTU;
          default: illegal    = 1'b1;
        endcase
      end
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src2_d   = 2'b01;
        result_src_d = 2'b01;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src2_d  = 2'b01;
        imm_src_d   = 3'b001;
      end
      OP_BR: begin
        imm_src_d  = 3'b010;
        alu_ctrl_d = ALU_SUB;
        case (func3)
          3'd0:    taken   = zero;
          3'd1:    taken   = ~zero;
          3'd4:    taken   = lt;
          3'd5:    taken   = bge;
          default: illegal = 1'b1;
        endcase
        pc_src_d = taken ? 2'b01 : 2'b00;
      end
      OP_JAL: begin
        pc_src_d     = 2'b01;
        imm_src_d    = 3'b011;
        result_src_d = 2'b10;
        reg_write_d  = 1'b1;
      end
      OP_JALR: begin
        if (func3 == 3'd0) begin
          pc_src_d     = 2'b10;
          alu_src2_d   = 2'b01;
          result_src_d = 2'b10;
          reg_write_d  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI: begin
        imm_src_d    = 3'b100;
        result_src_d = 2'b11;
        reg_write_d  = 1'b1;
      end
`ifdef CONTROLLER_ABS_EN
      OP_ABS: begin
        if (func3 == 3'd0) begin
          reg_write_d = 1'b1;
          abs_src_d   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
`endif
      default: illegal = 1'b1;
    endcase

    // Any illegal encoding collapses to a full NOP so nothing reaches state.
    if (illegal) begin
      pc_src_d     = 2'b00;
      result_src_d = 2'b00;
      mem_write_d  = 1'b0;
      alu_ctrl_d   = ALU_ADD;
      alu_src1_d   = 1'b0;
      alu_src2_d   = 2'b00;
      imm_src_d    = 3'b000;
      reg_write_d  = 1'b0;
      abs_src_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PCSrc      <= 2'b00;
      ResultSrc  <= 2'b00;
      MemWrite   <= 1'b0;
      ALUControl <= 3'b000;
      ALUSrc1    <= 1'b0;
      ALUSrc2    <= 2'b00;
      ImmSrc     <= 3'b000;
      RegWrite   <= 1'b0;
      Abs_src    <= 1'b0;
    end else begin
      PCSrc      <= pc_src_d;
      ResultSrc  <= result_src_d;
      MemWrite   <= mem_write_d;
      ALUControl <= alu_ctrl_d;
      ALUSrc1    <= alu_src1_d;
      ALUSrc2    <= alu_src2_d;
      ImmSrc     <= imm_src_d;
      RegWrite   <= reg_write_d;
      Abs_src    <= abs_src_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_control_unit
// Purpose  : Directed scoreboard bench for riscv_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero, bge, lt;
  logic [1:0] PCSrc, ResultSrc, ALUSrc2;
  logic       MemWrite, ALUSrc1, RegWrite, Abs_src;
  logic [2:0] ALUControl, ImmSrc;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  passed = 0;

  always #5 clk = ~clk;

  riscv_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .bge(bge), .lt(lt), .PCSrc(PCSrc), .ResultSrc(ResultSrc),
    .MemWrite(MemWrite), .ALUControl(ALUControl), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .Abs_src(Abs_src)
  );

  // Packed order: PCSrc, ResultSrc, MemWrite, ALUControl, ALUSrc1, ALUSrc2, ImmSrc, RegWrite, Abs_src
  function automatic logic [15:0] mk(input logic [1:0] pcs, input logic [1:0] rs,
                                     input logic mw, input logic [2:0] alu,
                                     input logic a1, input logic [1:0] a2,
                                     input logic [2:0] imm, input logic rw,
                                     input logic ab);
    return {pcs, rs, mw, alu, a1, a2, imm, rw, ab};
  endfunction

  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic z, input logic g, input logic l,
                      input logic [15:0] exp);
    sb_t item;
    sb_t got;
    logic [15:0] obs;
    rst = r; opcode = op; func3 = f3; func7 = f7; zero = z; bge = g; lt = l;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    obs = {PCSrc, ResultSrc, MemWrite, ALUControl, ALUSrc1, ALUSrc2, ImmSrc, RegWrite, Abs_src};
    checks++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      got = sb_q.pop_front();
      assert (obs === got.exp) passed++;
      else $error("FAIL %s observed %h expected %h", got.tag, obs, got.exp);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
    zero = 1'b0; bge = 1'b0; lt = 1'b0;
    @(posedge clk);
    #1;

    // Reset overrides a valid R-type add, then decode resumes after release.
    step("reset",      1, 7'd51, 3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("r_add",      0, 7'd51, 3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,1,0));
    step("r_sub",      0, 7'd51, 3'd0, 7'd32, 0, 0, 0, mk(0,0,0,3'd1,0,0,3'd0,1,0));
    step("r_and",      0, 7'd51, 3'd7, 7'd0,  0, 0, 0, mk(0,0,0,3'd2,0,0,3'd0,1,0));
    step("r_or",       0, 7'd51, 3'd6, 7'd0,  0, 0, 0, mk(0,0,0,3'd3,0,0,3'd0,1,0));
    step("r_xor",      0, 7'd51, 3'd4, 7'd0,  0, 0, 0, mk(0,0,0,3'd4,0,0,3'd0,1,0));
    step("r_slt",      0, 7'd51, 3'd2, 7'd0,  0, 0, 0, mk(0,0,0,3'd5,0,0,3'd0,1,0));
    step("r_sltu",     0, 7'd51, 3'd3, 7'd0,  0, 0, 0, mk(0,0,0,3'd6,0,0,3'd0,1,0));
    step("i_add",      0, 7'd19, 3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,1,3'd0,1,0));
    step("i_xor",      0, 7'd19, 3'd4, 7'd0,  0, 0, 0, mk(0,0,0,3'd4,0,1,3'd0,1,0));
    step("i_or",       0, 7'd19, 3'd6, 7'd0,  0, 0, 0, mk(0,0,0,3'd3,0,1,3'd0,1,0));
    step("i_slt",      0, 7'd19, 3'd2, 7'd0,  0, 0, 0, mk(0,0,0,3'd5,0,1,3'd0,1,0));
    step("i_sltu",     0, 7'd19, 3'd3, 7'd0,  0, 0, 0, mk(0,0,0,3'd6,0,1,3'd0,1,0));
    step("lw",         0, 7'd3,  3'd2, 7'd0,  0, 0, 0, mk(0,1,0,3'd0,0,1,3'd0,1,0));
    step("sw",         0, 7'd35, 3'd2, 7'd0,  0, 0, 0, mk(0,0,1,3'd0,0,1,3'd1,0,0));
    step("jal",        0, 7'd111,3'd5, 7'd0,  0, 0, 0, mk(1,2,0,3'd0,0,0,3'd3,1,0));
    step("jalr",       0, 7'd103,3'd0, 7'd0,  0, 0, 0, mk(2,2,0,3'd0,0,1,3'd0,1,0));
    step("jalr_bad",   0, 7'd103,3'd1, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("lui",        0, 7'd55, 3'd0, 7'd0,  0, 0, 0, mk(0,3,0,3'd0,0,0,3'd4,1,0));
    step("beq_nt",     0, 7'd99, 3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd1,0,0,3'd2,0,0));
    step("beq_t",      0, 7'd99, 3'd0, 7'd0,  1, 0, 0, mk(1,0,0,3'd1,0,0,3'd2,0,0));
    step("bne_nt",     0, 7'd99, 3'd1, 7'd0,  1, 0, 0, mk(0,0,0,3'd1,0,0,3'd2,0,0));
    step("bne_t",      0, 7'd99, 3'd1, 7'd0,  0, 0, 0, mk(1,0,0,3'd1,0,0,3'd2,0,0));
    step("bge_nt",     0, 7'd99, 3'd5, 7'd0,  0, 0, 1, mk(0,0,0,3'd1,0,0,3'd2,0,0));
    step("bge_t",      0, 7'd99, 3'd5, 7'd0,  0, 1, 0, mk(1,0,0,3'd1,0,0,3'd2,0,0));
    step("blt_nt",     0, 7'd99, 3'd4, 7'd0,  0, 1, 0, mk(0,0,0,3'd1,0,0,3'd2,0,0));
    step("blt_t",      0, 7'd99, 3'd4, 7'd0,  0, 0, 1, mk(1,0,0,3'd1,0,0,3'd2,0,0));
    step("ill_op0",    0, 7'd0,  3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("ill_r_f3_1", 0, 7'd51, 3'd1, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("ill_r_f7",   0, 7'd51, 3'd0, 7'd1,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("ill_i_f3_1", 0, 7'd19, 3'd1, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("ill_br_f3_2",0, 7'd99, 3'd2, 7'd0,  1, 1, 1, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("ill_br_f3_7",0, 7'd99, 3'd7, 7'd0,  1, 1, 1, mk(0,0,0,3'd0,0,0,3'd0,0,0));
`ifdef CONTROLLER_ABS_EN
    step("abs",        0, 7'd11, 3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,1,1));
`else
    step("abs_off",    0, 7'd11, 3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
`endif
    // Mid-stream reset on a taken jal, then recovery on the next edge.
    step("mid_reset",  1, 7'd111,3'd0, 7'd0,  0, 0, 0, mk(0,0,0,3'd0,0,0,3'd0,0,0));
    step("post_reset", 0, 7'd111,3'd0, 7'd0,  0, 0, 0, mk(1,2,0,3'd0,0,0,3'd3,1,0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_control_unit.md
# riscv_control_unit

Main decoder and ALU decoder for the RV32I-subset core. It takes the current instruction's opcode, funct3 and funct7 fields, plus the datapath comparison flags, and produces all datapath control signals. Outputs are registered, so they form the decode-stage control register that drives the execute datapath on the following cycle.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- opcode  input  7  instruction[6:0]
- func3  input  3  instruction[14:12]
- func7  input  7  instruction[31:25]
- zero  input  1  ALU result == 0
- bge  input  1  rs1 >= rs2 (signed)
- lt  input  1  rs1 < rs2 (signed)
- PCSrc  output  2  00 PC+4; 01 PC+imm; 10 ALU result (jalr)
- ResultSrc  output  2  00 ALU; 01 memory; 10 PC+4; 11 immediate
- MemWrite  output  1  store enable
- ALUControl  output  3  000 add; 001 sub; 010 and; 011 or; 100 xor; 101 slt; 110 sltu
- ALUSrc1  output  1  0 rs1; 1 PC
- ALUSrc2  output  2  00 rs2; 01 imm; 10 constant 4
- ImmSrc  output  3  000 I; 001 S; 010 B; 011 J; 100 U
- RegWrite  output  1  register-file write enable
- Abs_src  output  1  1 selects the absolute-value path into the result

## Operation
Decode is combinational into next-state values, which are captured by the output register. All fields not listed below are 0.

**R-type (opcode 51)**
- RegWrite=1, ALUSrc2=00, ResultSrc=00.
- func3=0: func7=0 → add; func7=32 → sub.
- func3=7 → and; 6 → or; 4 → xor; 2 → slt; 3 → sltu.

**I-ALU (opcode 19)**
- RegWrite=1, ALUSrc2=01, ImmSrc=000.
- func3: 0 add; 4 xor; 6 or; 2 slt; 3 sltu.

**lw (opcode 3)**
- RegWrite=1, ALUSrc2=01, ImmSrc=000, ALUControl=add, ResultSrc=01.

**sw (opcode 35)**
- MemWrite=1, ALUSrc2=01, ImmSrc=001, ALUControl=add, RegWrite=0.

**Branch (opcode 99)**
- ImmSrc=010, ALUControl=sub, ALUSrc2=00.
- PCSrc=01 when taken, else 00.
- Taken conditions: func3 0 (beq) when zero=1; func3 1 (bne) when zero=0; func3 4 (blt) when lt=1; func3 5 (bge) when bge=1.

**jal (opcode 111)**
- PCSrc=01, ImmSrc=011, ResultSrc=10, RegWrite=1. func3 is ignored.

**jalr (opcode 103, func3 0)**
- PCSrc=10, ALUSrc2=01, ImmSrc=000, ALUControl=add, ResultSrc=10, RegWrite=1.

**lui (opcode 55)**
- ImmSrc=100, ResultSrc=11, RegWrite=1.

**Illegal opcode or func3/func7 combination**
- All outputs are 0 (NOP): RegWrite=0, MemWrite=0, PCSrc=00.
- Examples: R-type func3=1; I-ALU func3=1; branch func3 2/3/6/7; jalr func3≠0.

## Timing
- All outputs are registered and update on the rising edge of clk. Latency from inputs (including the flags) to outputs is 1 cycle.
- rst=1 at a clock edge forces every output to 0 on that edge, overriding the inputs. This holds when reset is asserted mid-stream as well.
- Outputs resume decoding on the first edge after rst falls.
- Flag changes with a constant opcode are reflected one edge later; there is no extra state.
- There is no handshake. A new instruction is accepted every cycle.

## Configuration
- CONTROLLER_ABS_EN
  - Defined: opcode 11 (custom-0) with func3=0 decodes as abs. Outputs: RegWrite=1, ALUSrc2=00, ALUControl=add, ResultSrc=00, Abs_src=1.
  - Not defined: Abs_src is held at 0 and opcode 11 is illegal (NOP).

## Test plan
- **Reset:** assert rst with opcode 51 applied → every output is 0 after the edge. Deassert rst → add decode appears 1 edge later.
- **R/I-ALU sweep:**
  - R-type: func3 0/func7 0 → ALUControl 000; func7 32 → 001; func3 7 → 010; 6 → 011; 2 → 101; 3 → 110. RegWrite=1 and ALUSrc2=00 throughout.
  - opcode 19 with func3 0/4/6/2/3 → ALUControl 000/100/011/101/110, ALUSrc2=01, ImmSrc=000.
- **Memory and jumps:**
  - lw → ResultSrc=01, RegWrite=1.
  - sw → MemWrite=1, ImmSrc=001, RegWrite=0.
  - jal → PCSrc=01, ImmSrc=011, ResultSrc=10.
  - jalr → PCSrc=10.
  - lui → ImmSrc=100, ResultSrc=11.
- **Branches:**
  - beq: zero=0 → PCSrc=00; zero=1 → PCSrc=01.
  - bne: zero=1 → PCSrc=00; zero=0 → PCSrc=01.
  - bge: bge=1 → PCSrc=01.
  - blt: lt=0 → PCSrc=00; lt=1 → PCSrc=01.
- **Illegal:** opcode 0; R-type func3=1; branch func3=2 → all outputs 0.
- **Abs:** with CONTROLLER_ABS_EN defined, opcode 11 → Abs_src=1, RegWrite=1. Without the macro, the same input gives all outputs 0.
